// File: rtl/prog_counter_pkg.sv
// Shared operation encoding for the program counter and its return stack.
package prog_counter_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

endpackage

// File: rtl/prog_counter_ret_stack.sv
// LIFO return-address stack; only the occupancy counter is reset, storage is not.
module ret_stack #(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned STACK_DEPTH = 4,
    localparam int unsigned DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top_c,
    output logic [DW-1:0]    depth,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]    depth_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full_c  = (depth == DW'(STACK_DEPTH));
    assign empty_c = (depth == '0);
    assign wr_idx  = AW'(depth);
    assign rd_idx  = AW'(depth - DW'(1));
    assign top_c   = mem[rd_idx];

    always_comb begin
        depth_d = depth;
        if (push && !full_c) begin
            depth_d = depth + DW'(1);
        end else if (pop && !empty_c) begin
            depth_d = depth - DW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            depth <= '0;
        end else begin
            depth <= depth_d;
        end
    end

    // Storage write is suppressed during reset so a colliding push leaves no trace.
    always_ff @(posedge CLK) begin
        if (!RESET && push && !full_c) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Program counter with NEXT/JUMP/BRANCH/CALL/RET.
// Return stack, DEPTH and STK_ERR are live only when PROG_COUNTER_STACK_EN is defined.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter  int unsigned      WIDTH       = 8,
    parameter  int unsigned      STACK_DEPTH = 4,
    parameter  logic [WIDTH-1:0] RESET_VEC   = '0,
    localparam int unsigned      DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [OP_W-1:0]  OP,
    input  logic [WIDTH-1:0] TARGET,
    input  logic             COND,
    output logic [WIDTH-1:0] Y,
    output logic [DW-1:0]    DEPTH,
    output logic             STK_ERR
);

    op_e              op;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_inc;

    assign op    = op_e'(OP);
    assign y_inc = Y + WIDTH'(1);

`ifdef PROG_COUNTER_STACK_EN
    logic             push;
    logic             pop;
    logic             err_d;
    logic [WIDTH-1:0] top_c;
    logic             full_c;
    logic             empty_c;

    ret_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (push),
        .pop     (pop),
        .din     (y_inc),
        .top_c   (top_c),
        .depth   (DEPTH),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Next PC and stack control; overflow/underflow only raise the sticky flag.
    always_comb begin
        y_d   = Y;
        err_d = STK_ERR;
        push  = 1'b0;
        pop   = 1'b0;
        if (EN) begin
            case (op)
                OP_NEXT:   y_d = y_inc;
                OP_JUMP:   y_d = TARGET;
                OP_BRANCH: y_d = COND ? (Y + TARGET) : y_inc;
                OP_CALL: begin
                    if (!full_c) begin
                        push = 1'b1;
                        y_d  = TARGET;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty_c) begin
                        pop = 1'b1;
                        y_d = top_c;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: y_d = Y;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Y       <= RESET_VEC;
            STK_ERR <= 1'b0;
        end else begin
            Y       <= y_d;
            STK_ERR <= err_d;
        end
    end
`else
    assign DEPTH   = '0;
    assign STK_ERR = 1'b0;

    // Without a stack, CALL degenerates to JUMP and RET to NEXT.
    always_comb begin
        y_d = Y;
        if (EN) begin
            case (op)
                OP_NEXT:   y_d = y_inc;
                OP_JUMP:   y_d = TARGET;
                OP_BRANCH: y_d = COND ? (Y + TARGET) : y_inc;
                OP_CALL:   y_d = TARGET;
                OP_RET:    y_d = y_inc;
                default:   y_d = Y;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Y <= RESET_VEC;
        end else begin
            Y <= y_d;
        end
    end
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: driver queues expected state, monitor compares on falling edge.
module tb_prog_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned DW = $clog2(SD + 1);

    localparam logic [2:0] NXT = 3'd0;
    localparam logic [2:0] JMP = 3'd1;
    localparam logic [2:0] BRA = 3'd2;
    localparam logic [2:0] CAL = 3'd3;
    localparam logic [2:0] RTN = 3'd4;
    localparam logic [2:0] HLD = 3'd7;

    typedef struct {
        string          name;
        logic [W-1:0]   y;
        logic [DW-1:0]  d;
        logic           e;
    } exp_t;

    logic          CLK;
    logic          RESET;
    logic          EN;
    logic [2:0]    OP;
    logic [W-1:0]  TARGET;
    logic          COND;
    logic [W-1:0]  Y;
    logic [DW-1:0] DEPTH;
    logic          STK_ERR;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    prog_counter #(
        .WIDTH       (W),
        .STACK_DEPTH (SD),
        .RESET_VEC   (8'h00)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .OP      (OP),
        .TARGET  (TARGET),
        .COND    (COND),
        .Y       (Y),
        .DEPTH   (DEPTH),
        .STK_ERR (STK_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Apply one cycle of stimulus, then queue the state expected after its edge.
    task automatic step(input string name, input logic rst, input logic en,
                        input logic [2:0] op, input logic [W-1:0] tgt, input logic cnd,
                        input logic [W-1:0] ey, input logic [DW-1:0] ed, input logic ee);
        exp_t x;
        RESET  = rst;
        EN     = en;
        OP     = op;
        TARGET = tgt;
        COND   = cnd;
        @(posedge CLK);
        #1;
        x.name = name;
        x.y    = ey;
        x.d    = ed;
        x.e    = ee;
        sb.push_back(x);
    endtask

    // Monitor: outputs are stable mid-cycle, so compare each queued expectation there.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            tests_run = tests_run + 1;
            if (Y !== x.y || DEPTH !== x.d || STK_ERR !== x.e) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s: got Y=%h DEPTH=%0d STK_ERR=%b, want Y=%h DEPTH=%0d STK_ERR=%b",
                         x.name, Y, DEPTH, STK_ERR, x.y, x.d, x.e);
            end
        end
    end

    initial begin
        RESET = 1'b0; EN = 1'b0; OP = NXT; TARGET = '0; COND = 1'b0;

        step("reset",       1, 1, NXT, 8'h00, 0, 8'h00, 0, 0);
        step("next1",       0, 1, NXT, 8'h00, 0, 8'h01, 0, 0);
        step("next2",       0, 1, NXT, 8'h00, 0, 8'h02, 0, 0);
        step("next3",       0, 1, NXT, 8'h00, 0, 8'h03, 0, 0);
        step("en_low1",     0, 0, NXT, 8'h00, 0, 8'h03, 0, 0);
        step("en_low2",     0, 0, JMP, 8'h77, 1, 8'h03, 0, 0);
        step("jump_ff",     0, 1, JMP, 8'hFF, 0, 8'hFF, 0, 0);
        step("wrap",        0, 1, NXT, 8'h00, 0, 8'h00, 0, 0);
        step("jump_10",     0, 1, JMP, 8'h10, 0, 8'h10, 0, 0);
        step("branch_neg",  0, 1, BRA, 8'hFC, 1, 8'h0C, 0, 0);
        step("jump_10b",    0, 1, JMP, 8'h10, 0, 8'h10, 0, 0);
        step("branch_nt",   0, 1, BRA, 8'hFC, 0, 8'h11, 0, 0);
        step("branch_pos",  0, 1, BRA, 8'h20, 1, 8'h31, 0, 0);
        step("hold_op",     0, 1, HLD, 8'h55, 1, 8'h31, 0, 0);
        step("jump_05",     0, 1, JMP, 8'h05, 0, 8'h05, 0, 0);

`ifdef PROG_COUNTER_STACK_EN
        step("call_40",     0, 1, CAL, 8'h40, 0, 8'h40, 1, 0);
        step("call_80",     0, 1, CAL, 8'h80, 0, 8'h80, 2, 0);
        step("call_en_low", 0, 0, CAL, 8'h55, 0, 8'h80, 2, 0);
        step("ret_41",      0, 1, RTN, 8'h00, 0, 8'h41, 1, 0);
        step("ret_06",      0, 1, RTN, 8'h00, 0, 8'h06, 0, 0);

        step("reset2",      1, 1, NXT, 8'h00, 0, 8'h00, 0, 0);
        step("ret_empty",   0, 1, RTN, 8'h00, 0, 8'h00, 0, 1);
        step("err_sticky",  0, 1, NXT, 8'h00, 0, 8'h01, 0, 1);

        step("reset3",      1, 0, RTN, 8'h00, 0, 8'h00, 0, 0);
        step("fill1",       0, 1, CAL, 8'h10, 0, 8'h10, 1, 0);
        step("fill2",       0, 1, CAL, 8'h20, 0, 8'h20, 2, 0);
        step("fill3",       0, 1, CAL, 8'h30, 0, 8'h30, 3, 0);
        step("fill4",       0, 1, CAL, 8'h40, 0, 8'h40, 4, 0);
        step("overflow",    0, 1, CAL, 8'h99, 0, 8'h40, 4, 1);
        step("ret_after_of",0, 1, RTN, 8'h00, 0, 8'h31, 3, 1);
        step("ret_21",      0, 1, RTN, 8'h00, 0, 8'h21, 2, 1);
        step("ret_11",      0, 1, RTN, 8'h00, 0, 8'h11, 1, 1);
        step("ret_01",      0, 1, RTN, 8'h00, 0, 8'h01, 0, 1);

        step("reset4",      1, 1, NXT, 8'h00, 0, 8'h00, 0, 0);
        step("pre_call_a",  0, 1, CAL, 8'h40, 0, 8'h40, 1, 0);
        step("pre_call_b",  0, 1, CAL, 8'h50, 0, 8'h50, 2, 0);
        step("rst_vs_call", 1, 1, CAL, 8'h77, 0, 8'h00, 0, 0);
        step("empty_after", 0, 1, RTN, 8'h00, 0, 8'h00, 0, 1);
`else
        step("call_as_jmp", 0, 1, CAL, 8'h40, 0, 8'h40, 0, 0);
        step("ret_as_next", 0, 1, RTN, 8'h00, 0, 8'h41, 0, 0);
        step("ret_again",   0, 1, RTN, 8'h00, 0, 8'h42, 0, 0);
        step("call_99",     0, 1, CAL, 8'h99, 0, 8'h99, 0, 0);
        step("ret_9a",      0, 1, RTN, 8'h00, 0, 8'h9A, 0, 0);
        step("reset2",      1, 1, CAL, 8'h77, 0, 8'h00, 0, 0);
`endif

        EN = 1'b0;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        if (sb.size() != 0) begin
            tests_run = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
